// File: rtl/io_request_master_if.sv
// Cache-side request bus and I/O responder handshake for io_request_master.
// Signal names follow the responder contract so both ends agree on meaning.
interface io_request_master_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [27:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        err_clr;
  logic        io_rw_data;
  logic        io_valid_data;
  logic        io_ready_data;
  logic [27:0] mem_addr;
  logic [31:0] io_rd_data;
  logic [31:0] io_wr_data;

  modport master (
    input  cpu_req,
    input  cpu_we,
    input  cpu_addr,
    input  cpu_wdata,
    output cpu_busy,
    output cpu_done,
    output cpu_rdata,
    output cpu_err,
    input  err_clr,
    output io_rw_data,
    output io_valid_data,
    input  io_ready_data,
    output mem_addr,
    input  io_rd_data,
    output io_wr_data
  );

  modport slave (
    output cpu_req,
    output cpu_we,
    output cpu_addr,
    output cpu_wdata,
    input  cpu_busy,
    input  cpu_done,
    input  cpu_rdata,
    input  cpu_err,
    output err_clr,
    input  io_rw_data,
    input  io_valid_data,
    output io_ready_data,
    input  mem_addr,
    output io_rd_data,
    input  io_wr_data
  );
endinterface

// File: rtl/io_request_master.sv
// Single-outstanding cache-to-I/O request initiator.
// A watchdog aborts a transfer the responder never completes.
module io_request_master #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                rst,
  io_request_master_if.master bus
);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  localparam bit WD_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] LIMIT =
    WD_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           r_state;
  logic [CNT_W-1:0] r_wd;
  logic             r_valid;
  logic             r_rw;
  logic [27:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_busy;
  logic             r_done;
  logic [31:0]      r_rdata;
  logic             r_err;

  logic w_hs;
  logic w_expire;

  assign w_hs     = r_valid & bus.io_ready_data;
  assign w_expire = WD_EN && (r_wd == LIMIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_wd    <= '0;
      r_valid <= 1'b0;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // an abort below overrides a same-cycle clear
      if (bus.err_clr) r_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.cpu_req) begin
            r_rw    <= bus.cpu_we;
            r_addr  <= bus.cpu_addr;
            r_wdata <= bus.cpu_wdata;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_wd    <= '0;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (w_hs) begin
            if (!r_rw) r_rdata <= bus.io_rd_data;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (w_expire) begin
            if (!r_rw) r_rdata <= ERR_DATA;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else if (WD_EN) begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.io_valid_data = r_valid;
  assign bus.io_rw_data    = r_rw;
  assign bus.mem_addr      = r_addr;
  assign bus.io_wr_data    = r_wdata;
  assign bus.cpu_busy      = r_busy;
  assign bus.cpu_done      = r_done;
  assign bus.cpu_rdata     = r_rdata;
  assign bus.cpu_err       = r_err;

endmodule

// File: tb/tb_io_request_master.sv
// Directed bench for io_request_master: completions are
// checked against a queue of expected responses by a monitor.
module tb_io_request_master;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  io_request_master_if bus ();

  io_request_master #(
    .TIMEOUT (8),
    .CNT_W   (16),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          hs_cnt = 0;
  int          h0;
  logic [31:0] exp_rdata;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we,
                       input logic [27:0] a,
                       input logic [31:0] d);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.io_valid_data && bus.io_ready_data) hs_cnt++;
    if (bus.cpu_done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_unexpected_done: got done=1 want none, rdata %h",
                 bus.cpu_rdata);
      end else begin
        e = sb.pop_front();
        chk("sb_rdata", bus.cpu_rdata, e.rdata);
        chk("sb_err", 32'(bus.cpu_err), 32'(e.err));
      end
    end
  end

  initial begin
    rst               = 1'b0;
    bus.cpu_req       = 1'b0;
    bus.cpu_we        = 1'b0;
    bus.cpu_addr      = '0;
    bus.cpu_wdata     = '0;
    bus.err_clr       = 1'b0;
    bus.io_ready_data = 1'b0;
    bus.io_rd_data    = '0;
    exp_rdata         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.io_valid_data), 32'd0);
    chk("rst_busy", 32'(bus.cpu_busy), 32'd0);
    chk("rst_done", 32'(bus.cpu_done), 32'd0);
    chk("rst_err", 32'(bus.cpu_err), 32'd0);
    chk("rst_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_wdata", bus.io_wr_data, 32'd0);
    chk("rst_rw", 32'(bus.io_rw_data), 32'd0);
    step();
    rst = 1'b1;

    // 1: zero-wait write
    bus.io_ready_data = 1'b1;
    issue(1'b1, 28'h0000010, 32'hA5A5_0001);
    sb.push_back('{exp_rdata, 1'b0});
    h0 = hs_cnt;
    step();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("t1_valid", 32'(bus.io_valid_data), 32'd1);
    chk("t1_rw", 32'(bus.io_rw_data), 32'd1);
    chk("t1_addr", 32'(bus.mem_addr), 32'h0000010);
    chk("t1_wdata", bus.io_wr_data, 32'hA5A5_0001);
    chk("t1_busy", 32'(bus.cpu_busy), 32'd1);
    chk("t1_done_early", 32'(bus.cpu_done), 32'd0);
    step();
    @(negedge clk);
    chk("t1_done", 32'(bus.cpu_done), 32'd1);
    chk("t1_valid_drop", 32'(bus.io_valid_data), 32'd0);
    chk("t1_busy_drop", 32'(bus.cpu_busy), 32'd0);
    step();
    chk("t1_hs", 32'(hs_cnt - h0), 32'd1);

    // 2: read, five wait cycles
    bus.io_ready_data = 1'b0;
    bus.io_rd_data    = 32'h1234_5678;
    issue(1'b0, 28'h0000ABC, 32'h0);
    exp_rdata = 32'h1234_5678;
    sb.push_back('{exp_rdata, 1'b0});
    step();
    bus.cpu_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_valid_wait", 32'(bus.io_valid_data), 32'd1);
      chk("t2_addr_stable", 32'(bus.mem_addr), 32'h0000ABC);
      chk("t2_no_done", 32'(bus.cpu_done), 32'd0);
      step();
    end
    bus.io_ready_data = 1'b1;
    @(negedge clk);
    chk("t2_valid_6th", 32'(bus.io_valid_data), 32'd1);
    step();
    bus.io_ready_data = 1'b0;
    bus.io_rd_data    = 32'h0;
    @(negedge clk);
    chk("t2_done", 32'(bus.cpu_done), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t2_rdata_held", bus.cpu_rdata, 32'h1234_5678);

    // 3: watchdog abort on a read
    step();
    bus.io_rd_data = 32'h1111_1111;
    issue(1'b0, 28'h0000055, 32'h0);
    exp_rdata = 32'hDEADBEEF;
    sb.push_back('{exp_rdata, 1'b1});
    step();
    bus.cpu_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t3_valid_hold", 32'(bus.io_valid_data), 32'd1);
      step();
    end
    @(negedge clk);
    chk("t3_valid_drop", 32'(bus.io_valid_data), 32'd0);
    chk("t3_done", 32'(bus.cpu_done), 32'd1);
    chk("t3_err", 32'(bus.cpu_err), 32'd1);
    chk("t3_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    chk("t3_busy", 32'(bus.cpu_busy), 32'd0);
    step();
    @(negedge clk);
    chk("t3_err_sticky", 32'(bus.cpu_err), 32'd1);
    step();
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    @(negedge clk);
    chk("t3_err_clr", 32'(bus.cpu_err), 32'd0);

    // 4: ready in the last watchdog cycle wins
    step();
    bus.io_rd_data = 32'hCAFE_0004;
    issue(1'b0, 28'h0000066, 32'h0);
    exp_rdata = 32'hCAFE_0004;
    sb.push_back('{exp_rdata, 1'b0});
    step();
    bus.cpu_req = 1'b0;
    repeat (7) step();
    bus.io_ready_data = 1'b1;
    @(negedge clk);
    chk("t4_valid_8th", 32'(bus.io_valid_data), 32'd1);
    step();
    bus.io_ready_data = 1'b0;
    @(negedge clk);
    chk("t4_done", 32'(bus.cpu_done), 32'd1);
    chk("t4_err", 32'(bus.cpu_err), 32'd0);
    chk("t4_rdata", bus.cpu_rdata, 32'hCAFE_0004);

    // 5: back-to-back writes, request held high
    step();
    bus.io_ready_data = 1'b1;
    issue(1'b1, 28'h0000100, 32'hB0B0_0000);
    h0 = hs_cnt;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{exp_rdata, 1'b0});
      step();
      if (i < 3) begin
        bus.cpu_addr  = 28'h0000100 + 28'(i + 1);
        bus.cpu_wdata = 32'hB0B0_0000 + 32'(i + 1);
      end else begin
        bus.cpu_req = 1'b0;
      end
      @(negedge clk);
      chk("t5_addr", 32'(bus.mem_addr), 32'h0000100 + 32'(i));
      chk("t5_wdata", bus.io_wr_data, 32'hB0B0_0000 + 32'(i));
      step();
    end
    chk("t5_hs_count", 32'(hs_cnt - h0), 32'd4);
    bus.io_ready_data = 1'b0;

    // 6: reset during REQ drops the transfer
    step();
    issue(1'b0, 28'h0000077, 32'h0);
    h0 = hs_cnt;
    step();
    bus.cpu_req = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid_pre", 32'(bus.io_valid_data), 32'd1);
    step();
    rst = 1'b1;
    exp_rdata = 32'h0;
    @(negedge clk);
    chk("t6_valid_rst", 32'(bus.io_valid_data), 32'd0);
    chk("t6_busy_rst", 32'(bus.cpu_busy), 32'd0);
    chk("t6_done_rst", 32'(bus.cpu_done), 32'd0);
    chk("t6_rdata_rst", bus.cpu_rdata, 32'd0);
    chk("t6_hs_none", 32'(hs_cnt - h0), 32'd0);
    step();
    bus.io_ready_data = 1'b1;
    bus.io_rd_data    = 32'h0BAD_F00D;
    issue(1'b0, 28'h0000088, 32'h0);
    exp_rdata = 32'h0BAD_F00D;
    sb.push_back('{exp_rdata, 1'b0});
    step();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("t6_valid_post", 32'(bus.io_valid_data), 32'd1);
    chk("t6_addr_post", 32'(bus.mem_addr), 32'h0000088);
    step();
    bus.io_ready_data = 1'b0;
    @(negedge clk);
    chk("t6_done_post", 32'(bus.cpu_done), 32'd1);
    chk("t6_rdata_post", bus.cpu_rdata, 32'h0BAD_F00D);

    repeat (3) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
